// File: rtl/fwft_sync_fifo.sv
// Single-clock FIFO with selectable first-word-fall-through or registered read,
// exact occupancy count and one-cycle overflow/underflow pulses.
module fwft_sync_fifo #(
  parameter int FIFO_DEEP      = 1024,
  parameter int DATA_WIDTH     = 8,
  parameter int PROG_FULL_NUM  = 1000,
  parameter int PROG_EMPTY_NUM = 4,
  parameter int FWFT_EN        = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          full,
  output logic                          prog_full,
  output logic                          overflow,
  input  logic                          rd_en_i,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          valid,
  output logic                          empty,
  output logic                          prog_empty,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEEP):0]    data_count
);

  localparam int W = $clog2(FIFO_DEEP);
  localparam logic [W:0]   DEEP_C  = (W+1)'(FIFO_DEEP);
  localparam logic [W:0]   PF_C    = (W+1)'(PROG_FULL_NUM);
  localparam logic [W:0]   PE_C    = (W+1)'(PROG_EMPTY_NUM);
  localparam logic [W:0]   CONE_C  = (W+1)'(1);
  localparam logic [W-1:0] PONE_C  = W'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEEP];
  logic [W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [W:0]            count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Handshake: a request (wr_en_i / rd_en_i) is a one-cycle strobe; it is taken at
  // the edge only if the registered flag (full / empty) was clear at that edge,
  // otherwise it is dropped and reported one cycle later on overflow / underflow.
  assign full       = (count_q == DEEP_C);
  assign empty      = (count_q == '0);
  assign prog_full  = (count_q >= PF_C);
  assign prog_empty = (count_q <= PE_C);
  assign data_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign rd_data    = mem_q[rd_ptr_q];

  always_comb begin
    wr_acc   = wr_en_i && !full;
    rd_acc   = rd_en_i && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PONE_C;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PONE_C;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CONE_C;
      2'b01:   count_d = count_q - CONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en_i && full;
      underflow_q <= rd_en_i && empty;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_acc) mem_q[wr_ptr_q] <= din;
  end

  generate
    if (FWFT_EN != 0) begin : g_fwft
      assign dout  = empty ? '0 : rd_data;
      assign valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= rd_data;
        end
      end
      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Bench for fwft_sync_fifo: an FWFT instance and a registered-read instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_fwft_sync_fifo;

  localparam int DEEP = 16;
  localparam int DW   = 8;
  localparam int PF   = 12;
  localparam int PE   = 2;
  localparam int CW   = $clog2(DEEP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] din = '0;

  logic          a_full, a_pf, a_ovf, a_valid, a_empty, a_pe, a_udf;
  logic [DW-1:0] a_dout;
  logic [CW-1:0] a_count;
  logic          b_full, b_pf, b_ovf, b_valid, b_empty, b_pe, b_udf;
  logic [DW-1:0] b_dout;
  logic [CW-1:0] b_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic          m_valid_s = 1'b0;
  logic [DW-1:0] m_dout_s = '0;

  always #5 clk = ~clk;

  fwft_sync_fifo #(.FIFO_DEEP(DEEP), .DATA_WIDTH(DW), .PROG_FULL_NUM(PF),
                   .PROG_EMPTY_NUM(PE), .FWFT_EN(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr), .din(din), .full(a_full),
    .prog_full(a_pf), .overflow(a_ovf), .rd_en_i(rd), .dout(a_dout),
    .valid(a_valid), .empty(a_empty), .prog_empty(a_pe), .underflow(a_udf),
    .data_count(a_count));

  fwft_sync_fifo #(.FIFO_DEEP(DEEP), .DATA_WIDTH(DW), .PROG_FULL_NUM(PF),
                   .PROG_EMPTY_NUM(PE), .FWFT_EN(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr), .din(din), .full(b_full),
    .prog_full(b_pf), .overflow(b_ovf), .rd_en_i(rd), .dout(b_dout),
    .valid(b_valid), .empty(b_empty), .prog_empty(b_pe), .underflow(b_udf),
    .data_count(b_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of stored words; acceptance uses the occupancy before the edge.
  task automatic model_step();
    int  n = exp_q.size();
    bit  wacc, racc;
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_valid_s = 1'b0; m_dout_s = '0;
    end else begin
      wacc  = wr && (n < DEEP);
      racc  = rd && (n > 0);
      m_ovf = wr && (n == DEEP);
      m_udf = rd && (n == 0);
      m_valid_s = racc;
      if (racc) m_dout_s = exp_q.pop_front();
      if (wacc) exp_q.push_back(din);
    end
  endtask

  task automatic model_check();
    int            n = exp_q.size();
    logic [DW-1:0] head = (n > 0) ? exp_q[0] : '0;
    chk("a_count", 32'(a_count), 32'(n));
    chk("a_full",  32'(a_full),  32'(n == DEEP));
    chk("a_empty", 32'(a_empty), 32'(n == 0));
    chk("a_pfull", 32'(a_pf),    32'(n >= PF));
    chk("a_pempty",32'(a_pe),    32'(n <= PE));
    chk("a_ovf",   32'(a_ovf),   32'(m_ovf));
    chk("a_udf",   32'(a_udf),   32'(m_udf));
    chk("a_dout",  32'(a_dout),  32'(head));
    chk("a_valid", 32'(a_valid), 32'(n > 0));
    chk("b_count", 32'(b_count), 32'(n));
    chk("b_full",  32'(b_full),  32'(n == DEEP));
    chk("b_empty", 32'(b_empty), 32'(n == 0));
    chk("b_pfull", 32'(b_pf),    32'(n >= PF));
    chk("b_pempty",32'(b_pe),    32'(n <= PE));
    chk("b_ovf",   32'(b_ovf),   32'(m_ovf));
    chk("b_udf",   32'(b_udf),   32'(m_udf));
    chk("b_dout",  32'(b_dout),  32'(m_dout_s));
    chk("b_valid", 32'(b_valid), 32'(m_valid_s));
  endtask

  task automatic cycle(input logic r, input logic w, input logic [DW-1:0] d, input logic rr);
    @(negedge clk);
    rst_n = r; wr = w; din = d; rd = rr;
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  typedef struct {
    logic          rst_n;
    logic          wr;
    logic [DW-1:0] din;
    logic          rd;
    logic [CW-1:0] e_count;
    logic [DW-1:0] e_dout;
    logic          e_valid;
    logic          e_empty;
    logic          e_udf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int pw;
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h22, 1'b0, 5'd2, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 5'd3, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd2, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd1, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0};

    // Directed FWFT write/read-through sequence
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].rst_n, vecs[i].wr, vecs[i].din, vecs[i].rd);
      chk("vec_count", 32'(a_count), 32'(vecs[i].e_count));
      chk("vec_dout",  32'(a_dout),  32'(vecs[i].e_dout));
      chk("vec_valid", 32'(a_valid), 32'(vecs[i].e_valid));
      chk("vec_empty", 32'(a_empty), 32'(vecs[i].e_empty));
      chk("vec_udf",   32'(a_udf),   32'(vecs[i].e_udf));
    end

    // Overfill: 17 writes, word 17 dropped
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 1'b0);
      if (i == 15) chk("full_at_15", 32'(a_full), 32'd0);
      if (i == 16) chk("full_at_16", 32'(a_full), 32'd1);
      if (i == 16) chk("ovf_at_16",  32'(a_ovf),  32'd0);
    end
    chk("ovf_after_17",   32'(a_ovf),   32'd1);
    chk("count_after_17", 32'(a_count), 32'd16);
    // Full + simultaneous read/write: read taken, write dropped
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("rw_full_count", 32'(a_count), 32'd15);
    chk("rw_full_ovf",   32'(a_ovf),   32'd1);
    chk("rw_full_full",  32'(a_full),  32'd0);
    chk("rw_full_bdout", 32'(b_dout),  32'd1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_single", 32'(a_ovf), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      chk("drain_a", 32'(a_dout), 32'(i));
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("drain_b", 32'(b_dout), 32'(i));
    end
    chk("drained_empty", 32'(a_empty), 32'd1);
    // Empty + simultaneous read/write: write taken, read dropped
    cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    chk("rw_empty_count", 32'(a_count), 32'd1);
    chk("rw_empty_udf",   32'(a_udf),   32'd1);
    chk("rw_empty_dout",  32'(a_dout),  32'h5A);

    // Registered-read mode latency and hold
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("std_valid_pre", 32'(b_valid), 32'd0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("std_dout",  32'(b_dout),  32'hA5);
    chk("std_valid", 32'(b_valid), 32'd1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("std_hold_dout",  32'(b_dout),  32'hA5);
    chk("std_hold_valid", 32'(b_valid), 32'd0);

    // Programmable thresholds, then reset mid-traffic
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
      chk("prog_empty_fill", 32'(a_pe), 32'(i <= 2));
      chk("prog_full_fill",  32'(a_pf), 32'(i >= 12));
    end
    cycle(1'b0, 1'b1, 8'h77, 1'b1);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_pe",    32'(a_pe),    32'd1);
    chk("rst_pf",    32'(a_pf),    32'd0);
    chk("rst_ovf",   32'(a_ovf),   32'd0);
    chk("rst_udf",   32'(a_udf),   32'd0);
    chk("rst_bdout", 32'(b_dout),  32'd0);

    // Randomized traffic with fill/drain phases and occasional reset
    pw = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) pw = $urandom_range(10, 90);
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 99) < pw),
            8'($urandom),
            ($urandom_range(0, 99) < (100 - pw)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
